// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state, opcode and datapath select encodings shared by the control unit and its benches
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_IMM = 4'd2,
        S_WB_ALU   = 4'd3,
        S_ADDR     = 4'd4,
        S_MEMRD    = 4'd5,
        S_EXEC_M   = 4'd6,
        S_MEMWR    = 4'd7,
        S_PUSH_SP  = 4'd8,
        S_POP_SP   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'd0;
    localparam logic [3:0] OP_ANDI = 4'd1;
    localparam logic [3:0] OP_ORI  = 4'd2;
    localparam logic [3:0] OP_SHLI = 4'd3;
    localparam logic [3:0] OP_SHRI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_ADDM = 4'd7;
    localparam logic [3:0] OP_PUSH = 4'd8;
    localparam logic [3:0] OP_POP  = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_JMP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;

    localparam logic [1:0] SRCA_PC  = 2'd0;
    localparam logic [1:0] SRCA_SP  = 2'd1;
    localparam logic [1:0] SRCA_ACC = 2'd2;
    localparam logic [1:0] SRCA_MEM = 2'd3;

    localparam logic [1:0] SRCB_IMM  = 2'd0;
    localparam logic [1:0] SRCB_MEM  = 2'd1;
    localparam logic [1:0] SRCB_TWO  = 2'd2;
    localparam logic [1:0] SRCB_MTWO = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JIMM   = 2'd2;

    localparam logic [1:0] BC_EQ = 2'd0;
    localparam logic [1:0] BC_NE = 2'd1;
    localparam logic [1:0] BC_LT = 2'd2;
    localparam logic [1:0] BC_GE = 2'd3;

    localparam int MEM_TIMEOUT_DEF = 255;

    // States that stall on the memory handshake and therefore feed the timeout counter
    function automatic logic is_mem_state(input state_t s);
        return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_control_decode.sv
// control_decode: maps the IR opcode to its DECODE dispatch target, ALU operation and immediate sign-extension
module control_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] dispatch,
    output logic [2:0] alu_op,
    output logic       sign_ext
);

    // Opcode groups are contiguous, so range compares keep the dispatch table short
    always_comb begin
        dispatch = opcode <= OP_SHRI ? S_EXEC_IMM :
                   opcode <= OP_ADDM ? S_ADDR :
                   opcode == OP_PUSH ? S_PUSH_SP :
                   opcode == OP_POP  ? S_MEMRD :
                   opcode <= OP_BGE  ? S_BRANCH :
                   opcode == OP_JMP  ? S_JUMP : S_HALT;
        alu_op   = opcode == OP_ANDI ? ALU_AND :
                   opcode == OP_ORI  ? ALU_OR :
                   opcode == OP_SHLI ? ALU_SHL :
                   opcode == OP_SHRI ? ALU_SHR : ALU_ADD;
        sign_ext = opcode == OP_ADDI;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: fetch/decode/execute/memory/writeback sequencer for the 16-bit accumulator datapath
// Optional single-step mode via `define STEP_EN (adds the Step input); default build runs freely.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       MemReady,
`ifdef STEP_EN
    input  logic       Step,
`endif
    output logic       PCWrite,
    output logic       BranchCycle,
    output logic [1:0] BranchCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       ACCWrite,
    output logic       ACCSrc,
    output logic       SPWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       SIGNExt,
    output logic [1:0] PCSrc,
    output logic       Halted,
    output logic       Fault,
    output logic [3:0] State
);

    localparam logic [15:0] TIMEOUT_L = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        active;
    logic        waiting;
    logic        timeout;
    logic [3:0]  dispatch;
    logic [2:0]  dec_alu_op;
    logic        dec_sext;

    control_decode u_decode (
        .opcode   (Opcode),
        .dispatch (dispatch),
        .alu_op   (dec_alu_op),
        .sign_ext (dec_sext)
    );

`ifdef STEP_EN
    logic go_q, go_d;

    // A Step pulse arms one fetch; the arm is consumed when that fetch completes, so a held Step keeps re-arming
    always_comb go_d = Step | (go_q & ~(state_q == S_FETCH && MemReady));

    // Step arm register
    always_ff @(posedge CLK)
        if (Reset) go_q <= 1'b0;
        else       go_q <= go_d;

    assign active = go_q;
`else
    assign active = 1'b1;
`endif

    // An idle single-step FETCH is not waiting on memory, so it must not age the timeout
    assign waiting = is_mem_state(state_q) && (state_q != S_FETCH || active) && !MemReady;
    assign timeout = waiting && (cnt_q + 16'd1 == TIMEOUT_L);

    // State, timeout counter and sticky fault registers
    always_ff @(posedge CLK)
        if (Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 16'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end

    // Next-state logic; a memory timeout overrides every transition and parks the FSM in HALT
    always_comb begin
        state_d = state_q;
        cnt_d   = waiting ? cnt_q + 16'd1 : 16'd0;
        fault_d = fault_q | timeout;
        unique case (state_q)
            S_FETCH:    if (active && MemReady) state_d = S_DECODE;
            S_DECODE:   state_d = state_t'(dispatch);
            S_EXEC_IMM: state_d = S_WB_ALU;
            S_WB_ALU:   state_d = S_FETCH;
            S_ADDR:     state_d = Opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (MemReady) state_d = Opcode == OP_ADDM ? S_EXEC_M :
                                                Opcode == OP_POP  ? S_POP_SP : S_FETCH;
            S_EXEC_M:   state_d = S_WB_ALU;
            S_MEMWR:    if (MemReady) state_d = S_FETCH;
            S_PUSH_SP:  state_d = S_MEMWR;
            S_POP_SP:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_HALT;
        endcase
        if (timeout) state_d = S_HALT;
    end

    // Datapath controls; everything is forced low while Reset is high so an aborted instruction writes nothing
    always_comb begin
        PCWrite     = 1'b0;
        BranchCycle = 1'b0;
        BranchCond  = BC_EQ;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        ACCWrite    = 1'b0;
        ACCSrc      = 1'b0;
        SPWrite     = 1'b0;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        SIGNExt     = 1'b0;
        PCSrc       = PCSRC_ALU;
        Halted      = 1'b0;
        if (!Reset) begin
            unique case (state_q)
                S_FETCH: begin
                    MemRead = active;
                    if (active && MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        ALUSrcB = SRCB_TWO;
                    end
                end
                S_DECODE:   SIGNExt = 1'b1;
                S_EXEC_IMM: begin
                    ALUSrcA = SRCA_ACC;
                    ALUOp   = dec_alu_op;
                    SIGNExt = dec_sext;
                end
                S_WB_ALU:   ACCWrite = 1'b1;
                S_ADDR: begin
                    ALUSrcA = SRCA_SP;
                    SIGNExt = 1'b1;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (MemReady && (Opcode == OP_LW || Opcode == OP_POP)) begin
                        ACCWrite = 1'b1;
                        ACCSrc   = 1'b1;
                    end
                end
                S_EXEC_M: begin
                    ALUSrcA = SRCA_ACC;
                    ALUSrcB = SRCB_MEM;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_PUSH_SP: begin
                    ALUSrcA = SRCA_SP;
                    ALUSrcB = SRCB_MTWO;
                    SPWrite = 1'b1;
                end
                S_POP_SP: begin
                    ALUSrcA = SRCA_SP;
                    ALUSrcB = SRCB_TWO;
                    SPWrite = 1'b1;
                end
                S_BRANCH: begin
                    BranchCycle = 1'b1;
                    PCSrc       = PCSRC_ALUOUT;
                    BranchCond  = 2'(Opcode - OP_BEQ);
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_JIMM;
                end
                default:    Halted = 1'b1;
            endcase
        end
    end

    assign Fault = fault_q;
    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed-vector bench for the multicycle control FSM (short memory timeout of 8)
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Opcode = 4'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, BranchCycle, IRWrite, MemRead, MemWrite, IorD, ACCWrite, ACCSrc, SPWrite;
    logic       SIGNExt, Halted, Fault;
    logic [1:0] BranchCond, ALUSrcA, ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic [26:0] obs, exp_v;
    int total = 0;
    int bad = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(8)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .BranchCycle(BranchCycle), .BranchCond(BranchCond), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .ACCWrite(ACCWrite), .ACCSrc(ACCSrc),
        .SPWrite(SPWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .SIGNExt(SIGNExt),
        .PCSrc(PCSrc), .Halted(Halted), .Fault(Fault), .State(State)
    );

    always #5 CLK = ~CLK;

    // Enables: {PCWrite, BranchCycle, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite}
    assign obs = {State, PCWrite, BranchCycle, IRWrite, MemRead, MemWrite, ACCWrite, SPWrite,
                  IorD, ACCSrc, ALUSrcA, ALUSrcB, ALUOp, SIGNExt, PCSrc, BranchCond, Halted, Fault};

    function automatic logic [13:0] sl(int io, int ac, int a, int b, int op, int sx, int ps, int bc);
        return {1'(io), 1'(ac), 2'(a), 2'(b), 3'(op), 1'(sx), 2'(ps), 2'(bc)};
    endfunction

    function automatic logic [26:0] mk(logic [3:0] st, logic [6:0] en, logic [13:0] sel, logic [1:0] hf);
        return {st, en, sel, hf};
    endfunction

    task automatic cyc(input logic r, input logic mr, input logic [3:0] op);
        @(negedge CLK);
        Reset = r;
        MemReady = mr;
        Opcode = op;
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b1, 1'b1, 4'd0);
        cyc(1'b1, 1'b1, 4'd0);
        exp_v = mk(S_FETCH, 7'b0000000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_hold obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd0);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_fetch_wait obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_addi;
        cyc(1'b0, 1'b1, 4'd0);
        exp_v = mk(S_FETCH, 7'b1011000, sl(0,0,0,2,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_fetch obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd0);
        exp_v = mk(S_DECODE, 7'b0000000, sl(0,0,0,0,0,1,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_decode obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd0);
        exp_v = mk(S_EXEC_IMM, 7'b0000000, sl(0,0,2,0,0,1,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_exec obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd0);
        exp_v = mk(S_WB_ALU, 7'b0000010, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_wb obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd0);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addi_next_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_imm_ops;
        int ops[4] = '{2, 3, 4, 5};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 4'(i + 1));
            cyc(1'b0, 1'b1, 4'(i + 1));
            cyc(1'b0, 1'b1, 4'(i + 1));
            exp_v = mk(S_EXEC_IMM, 7'b0000000, sl(0,0,2,0,ops[i],0,0,0), 2'b00);
            total++; if (obs !== exp_v) begin bad++; $display("FAIL imm_op%0d_exec obs=%h exp=%h", i + 1, obs, exp_v); end
            cyc(1'b0, 1'b1, 4'(i + 1));
        end
    endtask

    task automatic test_lw_wait;
        cyc(1'b0, 1'b1, 4'd5);
        cyc(1'b0, 1'b1, 4'd5);
        cyc(1'b0, 1'b1, 4'd5);
        exp_v = mk(S_ADDR, 7'b0000000, sl(0,0,1,0,0,1,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL lw_addr obs=%h exp=%h", obs, exp_v); end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 4'd5);
            exp_v = mk(S_MEMRD, 7'b0001000, sl(1,0,0,0,0,0,0,0), 2'b00);
            total++; if (obs !== exp_v) begin bad++; $display("FAIL lw_memrd_wait%0d obs=%h exp=%h", k, obs, exp_v); end
        end
        cyc(1'b0, 1'b1, 4'd5);
        exp_v = mk(S_MEMRD, 7'b0001010, sl(1,1,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL lw_memrd_ready obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd5);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL lw_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_addm;
        cyc(1'b0, 1'b1, 4'd7);
        cyc(1'b0, 1'b1, 4'd7);
        cyc(1'b0, 1'b1, 4'd7);
        cyc(1'b0, 1'b1, 4'd7);
        exp_v = mk(S_MEMRD, 7'b0001000, sl(1,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addm_memrd obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd7);
        exp_v = mk(S_EXEC_M, 7'b0000000, sl(0,0,2,1,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addm_exec_m obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd7);
        exp_v = mk(S_WB_ALU, 7'b0000010, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addm_wb obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd7);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL addm_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_sw;
        cyc(1'b0, 1'b1, 4'd6);
        cyc(1'b0, 1'b1, 4'd6);
        cyc(1'b0, 1'b1, 4'd6);
        cyc(1'b0, 1'b1, 4'd6);
        exp_v = mk(S_MEMWR, 7'b0000100, sl(1,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL sw_memwr obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd6);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL sw_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_push_pop;
        cyc(1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b1, 4'd8);
        exp_v = mk(S_PUSH_SP, 7'b0000001, sl(0,0,1,3,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL push_sp obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd8);
        exp_v = mk(S_MEMWR, 7'b0000100, sl(1,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL push_memwr obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd9);
        exp_v = mk(S_FETCH, 7'b1011000, sl(0,0,0,2,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL pop_fetch obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd9);
        cyc(1'b0, 1'b1, 4'd9);
        exp_v = mk(S_MEMRD, 7'b0001010, sl(1,1,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL pop_memrd obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd9);
        exp_v = mk(S_POP_SP, 7'b0000001, sl(0,0,1,2,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL pop_sp obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd9);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL pop_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 4'(10 + i));
            cyc(1'b0, 1'b1, 4'(10 + i));
            cyc(1'b0, 1'b1, 4'(10 + i));
            exp_v = mk(S_BRANCH, 7'b0100000, sl(0,0,0,0,0,0,1,i), 2'b00);
            total++; if (obs !== exp_v) begin bad++; $display("FAIL branch_op%0d obs=%h exp=%h", 10 + i, obs, exp_v); end
        end
        cyc(1'b0, 1'b0, 4'd13);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL branch_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_jump;
        cyc(1'b0, 1'b1, 4'd14);
        cyc(1'b0, 1'b1, 4'd14);
        cyc(1'b0, 1'b1, 4'd14);
        exp_v = mk(S_JUMP, 7'b1000000, sl(0,0,0,0,0,0,2,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL jump obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd14);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL jump_back_fetch obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_memwr;
        cyc(1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b1, 4'd8);
        cyc(1'b0, 1'b0, 4'd8);
        cyc(1'b0, 1'b0, 4'd8);
        exp_v = mk(S_MEMWR, 7'b0000100, sl(1,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL memwr_wait obs=%h exp=%h", obs, exp_v); end
        cyc(1'b1, 1'b1, 4'd8);
        exp_v = mk(S_MEMWR, 7'b0000000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL memwr_reset_cycle obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b0, 4'd8);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL memwr_after_reset obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_halt;
        cyc(1'b0, 1'b1, 4'd15);
        cyc(1'b0, 1'b1, 4'd15);
        cyc(1'b0, 1'b1, 4'd15);
        exp_v = mk(S_HALT, 7'b0000000, sl(0,0,0,0,0,0,0,0), 2'b10);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL halt_enter obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL halt_absorb obs=%h exp=%h", obs, exp_v); end
        cyc(1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 4'd0);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL halt_reset_exit obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_timeout;
        cyc(1'b1, 1'b0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b0, 4'd0);
            exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
            total++; if (obs !== exp_v) begin bad++; $display("FAIL timeout_wait%0d obs=%h exp=%h", k, obs, exp_v); end
        end
        cyc(1'b0, 1'b1, 4'd0);
        exp_v = mk(S_HALT, 7'b0000000, sl(0,0,0,0,0,0,0,0), 2'b11);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL timeout_fault obs=%h exp=%h", obs, exp_v); end
        cyc(1'b0, 1'b1, 4'd0);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL timeout_sticky obs=%h exp=%h", obs, exp_v); end
        cyc(1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 4'd0);
        exp_v = mk(S_FETCH, 7'b0001000, sl(0,0,0,0,0,0,0,0), 2'b00);
        total++; if (obs !== exp_v) begin bad++; $display("FAIL timeout_reset_clear obs=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_imm_ops;
        test_lw_wait;
        test_addm;
        test_sw;
        test_push_pop;
        test_branch;
        test_jump;
        test_reset_memwr;
        test_halt;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
